// File: rtl/kbd_event_scheduler.sv
// rtl/kbd_event_scheduler.sv - PS/2 arrow-key make/break parser with held-state tracking and event FIFO
module kbd_event_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  CODE_UP    = 8'h75,
    parameter logic [7:0]  CODE_RIGHT = 8'h74,
    parameter logic [7:0]  CODE_LEFT  = 8'h6B
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       evt_ready,
    input  logic       clear_overflow,
    output logic       evt_valid,
    output logic [1:0] evt_key,
    output logic       evt_pressed,
    output logic [2:0] key_held,
    output logic       overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       held_q, held_d;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [1:0] key_id;
    logic [2:0] key_mask;
    logic       key_hit;
    logic       push;
    logic [2:0] push_entry;
    logic       pop;
    logic       full;
    logic       wr_en;
    logic       drop;
    logic [2:0] head;

    // key_mask places the key in {up,right,left} bit order
    always_comb begin
        key_id   = 2'd0;
        key_mask = 3'b000;
        if (rx_data == CODE_UP) begin
            key_id   = 2'd1;
            key_mask = 3'b100;
        end else if (rx_data == CODE_RIGHT) begin
            key_id   = 2'd2;
            key_mask = 3'b010;
        end else if (rx_data == CODE_LEFT) begin
            key_id   = 2'd3;
            key_mask = 3'b001;
        end
    end

    assign key_hit = (key_id != 2'd0);

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        push       = 1'b0;
        push_entry = 3'b000;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == BYTE_EXT)      state_d = ST_EXT;
                    else if (rx_data == BYTE_BRK) state_d = ST_BRK;
                    else                          state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_data == BYTE_BRK)      state_d = ST_EXT_BRK;
                    else if (rx_data == BYTE_EXT) state_d = ST_EXT;
                    else begin
                        state_d = ST_IDLE;
                        // typematic repeats of an already-held key are swallowed
                        if (key_hit && ((held_q & key_mask) == 3'b000)) begin
                            held_d     = held_q | key_mask;
                            push       = 1'b1;
                            push_entry = {key_id, 1'b1};
                        end
                    end
                end
                ST_BRK: begin
                    if (rx_data == BYTE_EXT)      state_d = ST_EXT;
                    else if (rx_data == BYTE_BRK) state_d = ST_BRK;
                    else                          state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    if (rx_data == BYTE_EXT)      state_d = ST_EXT;
                    else if (rx_data == BYTE_BRK) state_d = ST_EXT_BRK;
                    else begin
                        state_d = ST_IDLE;
                        if (key_hit && ((held_q & key_mask) != 3'b000)) begin
                            held_d     = held_q & ~key_mask;
                            push       = 1'b1;
                            push_entry = {key_id, 1'b0};
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    assign full      = (count_q == FULL_CNT);
    // a pop in the same cycle frees the slot the push needs
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (drop)                ovf_d = 1'b1;
        else if (clear_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            held_q   <= 3'b000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 3'b000;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign evt_key     = evt_valid ? head[2:1] : 2'd0;
    assign evt_pressed = evt_valid ? head[0] : 1'b0;
    assign key_held    = held_q;
    assign overflow    = ovf_q;

endmodule
